rx_frame_ctrl: RTL and testbench

// Frame-level controller behind the RGMII RX MAC byte stream, in the MAC clock domain.
// - Hunts preamble/SFD, then sequences each frame through dest-MAC filtering, length policing and FCS strip.
// - Emits the frame (dest MAC .. last payload byte) as a valid/last/err byte stream to the book parser.
// - Keeps good/dropped/errored frame counters.

---
 rtl/rx_frame_ctrl_pkg.sv | 31 +++
 rtl/rx_frame_ctrl_if.sv | 27 ++
 rtl/rx_frame_ctrl_byte_delay_line.sv | 46 ++++
 rtl/rx_frame_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_rx_frame_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rx_frame_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : eth_pkg
// Purpose  : Shared Ethernet RX constants, FSM state type and the
//            destination-address filter helper for rx_frame_ctrl.
// Revision : 1.0  initial release
// ============================================================================
package eth_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PRE  = 3'd1,
    HDR  = 3'd2,
    PAY  = 3'd3,
    DROP = 3'd4
  } rx_frm_state_t;

  localparam logic [7:0]  ETH_PREAMBLE  = 8'h55;
  localparam logic [7:0]  ETH_SFD       = 8'hD5;
  localparam int          ETH_FCS_LEN   = 4;
  localparam logic [47:0] ETH_MAC_BCAST = 48'hFFFF_FFFF_FFFF;

  // Accept when promiscuous, addressed to this station, or broadcast.
  function automatic logic destMatch(input logic [47:0] dest,
                                     input logic [47:0] station,
                                     input logic        promisc);
    return promisc || (dest == station) || (dest == ETH_MAC_BCAST);
  endfunction

endpackage
`default_nettype wire

// File: rtl/rx_frame_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : rx_frame_ctrl_if
// Purpose  : MAC byte stream in / frame byte stream out of rx_frame_ctrl.
//            master = stream source and frame sink, slave = the controller.
// Revision : 1.0  initial release
// ============================================================================
interface rx_frame_ctrl_if;
  logic [7:0] rxDataIn;
  logic       rxDataValidIn;
  logic       rxDataLastIn;
  logic [7:0] frmDataOut;
  logic       frmValidOut;
  logic       frmLastOut;
  logic       frmErrOut;

  modport master (
    output rxDataIn, rxDataValidIn, rxDataLastIn,
    input  frmDataOut, frmValidOut, frmLastOut, frmErrOut
  );

  modport slave (
    input  rxDataIn, rxDataValidIn, rxDataLastIn,
    output frmDataOut, frmValidOut, frmLastOut, frmErrOut
  );
endinterface
`default_nettype wire

// File: rtl/rx_frame_ctrl_byte_delay_line.sv
`default_nettype none
// ============================================================================
// Module   : byte_delay_line
// Purpose  : DEPTH-byte shift register holding the newest bytes of a frame.
//            Exposes the oldest byte, the whole contents (oldest in the MSBs)
//            and a full flag. Flush has priority over shift.
// Revision : 1.0  initial release
// ============================================================================
module byte_delay_line #(
  parameter int DEPTH = 5
) (
  input  logic               clkIn,
  input  logic               rstNIn,
  input  logic               shiftIn,
  input  logic               flushIn,
  input  logic [7:0]         dataIn,
  output logic [7:0]         oldestOut,
  output logic [DEPTH*8-1:0] contentsOut,
  output logic               fullOut
);
  localparam int FILL_W = $clog2(DEPTH + 1);

  logic [DEPTH*8-1:0] rData;
  logic [FILL_W-1:0]  rFill;

  // Shift newest byte into the LSBs; fill level saturates at DEPTH.
  always_ff @(posedge clkIn or negedge rstNIn) begin
    if (!rstNIn) begin
      rData <= '0;
      rFill <= '0;
    end else if (flushIn) begin
      rData <= '0;
      rFill <= '0;
    end else if (shiftIn) begin
      rData <= {rData[DEPTH*8-9:0], dataIn};
      if (rFill != FILL_W'(DEPTH)) begin
        rFill <= rFill + FILL_W'(1);
      end
    end
  end

  assign oldestOut   = rData[DEPTH*8-1 -: 8];
  assign contentsOut = rData;
  assign fullOut     = (rFill == FILL_W'(DEPTH));
endmodule
`default_nettype wire

// File: rtl/rx_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : rx_frame_ctrl
// Purpose  : Frame controller behind the RX MAC: preamble/SFD hunt, dest-MAC
//            filter, runt/giant policing, FCS strip and frame statistics.
// Revision : 1.0  initial release
// ============================================================================
module rx_frame_ctrl
  import eth_pkg::*;
#(
  parameter int MAX_FRAME_LEN = 1518,
  parameter int MIN_FRAME_LEN = 64,
  parameter int CNT_W         = 32
) (
  input  logic                clkIn,
  input  logic                rstNIn,
  input  logic [47:0]         macAddrIn,
  input  logic                promiscIn,
  rx_frame_ctrl_if.slave      frmIf,
  output logic [CNT_W-1:0]    goodCntOut,
  output logic [CNT_W-1:0]    dropCntOut,
  output logic [CNT_W-1:0]    errCntOut
);
  localparam logic [2:0] ST_IDLE = IDLE;
  localparam logic [2:0] ST_PRE  = PRE;
  localparam logic [2:0] ST_HDR  = HDR;
  localparam logic [2:0] ST_PAY  = PAY;
  localparam logic [2:0] ST_DROP = DROP;

  // The delay line holds dest bytes 0..4 during HDR and the FCS-sized tail in PAY.
  localparam int DL_DEPTH = ETH_FCS_LEN + 1;
  localparam int LEN_W    = $clog2(MAX_FRAME_LEN + 2);
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_FRAME_LEN);
  localparam logic [LEN_W-1:0] LEN_SAT = LEN_W'(MAX_FRAME_LEN + 1);
  localparam logic [LEN_W-1:0] LEN_MIN = LEN_W'(MIN_FRAME_LEN);

  logic [2:0]            rState, wNextState;
  logic [LEN_W-1:0]      rLen;
  logic                  wByte, wShift, wFlush, wLenClr;
  logic                  wEmit, wEmitLast, wEmitErr;
  logic                  wIncGood, wIncDrop, wIncErr;
  logic [7:0]            wOldest;
  logic [DL_DEPTH*8-1:0] wHeld;
  logic                  wFull, wMatch;

  // A last pulse overrides a coincident valid byte.
  assign wByte  = frmIf.rxDataValidIn & ~frmIf.rxDataLastIn;
  assign wMatch = destMatch({wHeld, frmIf.rxDataIn}, macAddrIn, promiscIn);

  byte_delay_line #(.DEPTH(DL_DEPTH)) uDelay (
    .clkIn       (clkIn),
    .rstNIn      (rstNIn),
    .shiftIn     (wShift),
    .flushIn     (wFlush),
    .dataIn      (frmIf.rxDataIn),
    .oldestOut   (wOldest),
    .contentsOut (wHeld),
    .fullOut     (wFull)
  );

  // Next-state, emit and counter-increment decisions for the arriving cycle.
  always_comb begin
    wNextState = rState;
    wShift     = 1'b0;
    wLenClr    = 1'b0;
    wEmit      = 1'b0;
    wEmitLast  = 1'b0;
    wEmitErr   = 1'b0;
    wIncGood   = 1'b0;
    wIncDrop   = 1'b0;
    wIncErr    = 1'b0;
    case (rState)
      ST_IDLE: begin
        if (wByte) begin
          if (frmIf.rxDataIn == ETH_PREAMBLE) begin
            wNextState = ST_PRE;
          end else begin
            wNextState = ST_DROP;
            wIncDrop   = 1'b1;
          end
        end
      end
      ST_PRE: begin
        if (frmIf.rxDataLastIn) begin
          wNextState = ST_IDLE;
          wIncDrop   = 1'b1;
        end else if (wByte) begin
          if (frmIf.rxDataIn == ETH_SFD) begin
            wNextState = ST_HDR;
            wLenClr    = 1'b1;
          end else if (frmIf.rxDataIn != ETH_PREAMBLE) begin
            wNextState = ST_DROP;
            wIncDrop   = 1'b1;
          end
        end
      end
      ST_HDR: begin
        if (frmIf.rxDataLastIn) begin
          wNextState = ST_IDLE;
          wIncDrop   = 1'b1;
        end else if (wByte) begin
          // Full means bytes 0..4 are held, so this byte is dest byte 5.
          if (!wFull) begin
            wShift = 1'b1;
          end else if (wMatch) begin
            wShift     = 1'b1;
            wEmit      = 1'b1;
            wNextState = ST_PAY;
          end else begin
            wNextState = ST_DROP;
            wIncDrop   = 1'b1;
          end
        end
      end
      ST_PAY: begin
        if (frmIf.rxDataLastIn) begin
          // Oldest held byte is the final payload byte; the rest is FCS.
          wEmit      = 1'b1;
          wEmitLast  = 1'b1;
          wEmitErr   = (rLen < LEN_MIN);
          wIncErr    = wEmitErr;
          wIncGood   = ~wEmitErr;
          wNextState = ST_IDLE;
        end else if (wByte) begin
          if (rLen == LEN_MAX) begin
            wEmit      = 1'b1;
            wEmitLast  = 1'b1;
            wEmitErr   = 1'b1;
            wIncErr    = 1'b1;
            wNextState = ST_DROP;
          end else begin
            wShift = 1'b1;
            wEmit  = 1'b1;
          end
        end
      end
      ST_DROP: begin
        if (frmIf.rxDataLastIn) begin
          wNextState = ST_IDLE;
        end
      end
      default: wNextState = ST_IDLE;
    endcase
    wFlush = (wNextState != ST_HDR) && (wNextState != ST_PAY);
  end

  // Frame state register.
  always_ff @(posedge clkIn or negedge rstNIn) begin
    if (!rstNIn) rState <= ST_IDLE;
    else         rState <= wNextState;
  end

  // Bytes since SFD, saturating one past the maximum frame length.
  always_ff @(posedge clkIn or negedge rstNIn) begin
    if (!rstNIn) begin
      rLen <= '0;
    end else if (wLenClr) begin
      rLen <= '0;
    end else if (wByte && (rState == ST_HDR || rState == ST_PAY) && rLen != LEN_SAT) begin
      rLen <= rLen + LEN_W'(1);
    end
  end

  // Registered frame output stream.
  always_ff @(posedge clkIn or negedge rstNIn) begin
    if (!rstNIn) begin
      frmIf.frmDataOut  <= '0;
      frmIf.frmValidOut <= 1'b0;
      frmIf.frmLastOut  <= 1'b0;
      frmIf.frmErrOut   <= 1'b0;
    end else begin
      frmIf.frmValidOut <= wEmit;
      frmIf.frmLastOut  <= wEmitLast;
      frmIf.frmErrOut   <= wEmitErr;
      if (wEmit) frmIf.frmDataOut <= wOldest;
    end
  end

  // Wrapping frame statistics.
  always_ff @(posedge clkIn or negedge rstNIn) begin
    if (!rstNIn) begin
      goodCntOut <= '0;
      dropCntOut <= '0;
      errCntOut  <= '0;
    end else begin
      if (wIncGood) goodCntOut <= goodCntOut + CNT_W'(1);
      if (wIncDrop) dropCntOut <= dropCntOut + CNT_W'(1);
      if (wIncErr)  errCntOut  <= errCntOut + CNT_W'(1);
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_rx_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_rx_frame_ctrl
// Purpose  : Self-checking bench for rx_frame_ctrl with a frame-level model.
// Revision : 1.0  initial release
// ============================================================================
module tb_rx_frame_ctrl;
  localparam int MAX_LEN = 1518;
  localparam int MIN_LEN = 64;
  localparam int CW      = 32;
  localparam logic [47:0] STATION = 48'h02_11_22_33_44_55;
  localparam logic [47:0] BCAST   = 48'hFFFF_FFFF_FFFF;

  logic          clkIn  = 1'b0;
  logic          rstNIn = 1'b0;
  logic [47:0]   macAddr;
  logic          promisc;
  logic [CW-1:0] goodCnt, dropCnt, errCnt;

  rx_frame_ctrl_if bus ();

  rx_frame_ctrl #(.MAX_FRAME_LEN(MAX_LEN), .MIN_FRAME_LEN(MIN_LEN), .CNT_W(CW)) dut (
    .clkIn      (clkIn),
    .rstNIn     (rstNIn),
    .macAddrIn  (macAddr),
    .promiscIn  (promisc),
    .frmIf      (bus),
    .goodCntOut (goodCnt),
    .dropCntOut (dropCnt),
    .errCntOut  (errCnt)
  );

  always #5 clkIn = ~clkIn;

  int checks = 0;
  int errors = 0;
  int expGood = 0, expDrop = 0, expErr = 0;
  // Records are {err&last, last, data}.
  logic [9:0] gotQ[$];
  logic [9:0] expQ[$];

  always @(negedge clkIn)
    if (rstNIn && bus.frmValidOut)
      gotQ.push_back({bus.frmErrOut & bus.frmLastOut, bus.frmLastOut, bus.frmDataOut});

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Frame-level reference: what should come out for the bytes on the wire.
  task automatic model_frame(input logic [7:0] q[$]);
    int i, n;
    logic [7:0]  body[$];
    logic [47:0] dest;
    bit bad;
    if (q.size() == 0) return;
    if (q[0] != 8'h55) begin expDrop++; return; end
    i = 1;
    while (i < q.size() && q[i] == 8'h55) i++;
    if (i >= q.size() || q[i] != 8'hD5) begin expDrop++; return; end
    body = q[i+1:$];
    if (body.size() < 6) begin expDrop++; return; end
    dest = {body[0], body[1], body[2], body[3], body[4], body[5]};
    if (!(promisc || dest == macAddr || dest == BCAST)) begin expDrop++; return; end
    if (body.size() > MAX_LEN) begin
      n = MAX_LEN - 4; bad = 1'b1;
    end else begin
      n = body.size() - 4; bad = (body.size() < MIN_LEN);
    end
    for (int k = 0; k < n; k++)
      expQ.push_back({(k == n-1) && bad, k == n-1, body[k]});
    if (bad) expErr++; else expGood++;
  endtask

  task automatic build_frame(output logic [7:0] q[$], input int preLen,
                             input logic [47:0] dest, input int bodyLen);
    q = {};
    repeat (preLen) q.push_back(8'h55);
    q.push_back(8'hD5);
    for (int k = 0; k < bodyLen; k++)
      q.push_back(k < 6 ? dest[47-8*k -: 8] : 8'($urandom));
  endtask

  // Called at #1 after a rising edge; returns at the same phase.
  task automatic drive_frame(input logic [7:0] q[$], input bit gaps);
    foreach (q[k]) begin
      if (gaps && $urandom_range(0, 5) == 0) begin
        bus.rxDataValidIn = 1'b0;
        @(posedge clkIn); #1;
      end
      bus.rxDataValidIn = 1'b1;
      bus.rxDataIn      = q[k];
      @(posedge clkIn); #1;
    end
    bus.rxDataValidIn = 1'b0;
    bus.rxDataLastIn  = 1'b1;
    @(posedge clkIn); #1;
    bus.rxDataLastIn  = 1'b0;
    repeat (3) @(posedge clkIn);
    #1;
  endtask

  function automatic int frame_diff();
    int n = (gotQ.size() < expQ.size()) ? gotQ.size() : expQ.size();
    for (int k = 0; k < n; k++) if (gotQ[k] !== expQ[k]) return k;
    if (gotQ.size() != expQ.size()) return n;
    return -1;
  endfunction

  task automatic run_frame(input int preLen, input logic [47:0] dest, input int bodyLen);
    logic [7:0] q[$];
    build_frame(q, preLen, dest, bodyLen);
    gotQ = {}; expQ = {};
    model_frame(q);
    drive_frame(q, 1'b0);
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clkIn);
    #1;
    checks++;
    if ({bus.frmValidOut, bus.frmLastOut, bus.frmErrOut, bus.frmDataOut, goodCnt, dropCnt, errCnt} !== '0) begin
      errors++;
      $display("FAIL reset_state: got v=%b l=%b e=%b d=%h good=%0d drop=%0d err=%0d, required all 0",
               bus.frmValidOut, bus.frmLastOut, bus.frmErrOut, bus.frmDataOut, goodCnt, dropCnt, errCnt);
    end
    rstNIn = 1'b1;
    @(posedge clkIn); #1;
  endtask

  task automatic test_good();
    int d;
    run_frame(7, STATION, 70);
    d = frame_diff();
    checks++;
    if (d != -1) begin errors++; $display("FAIL good_stream: diff at %0d, got %0d bytes, required %0d", d, gotQ.size(), expQ.size()); end
    checks++;
    if (gotQ.size() !== 66 || gotQ[gotQ.size()-1][9:8] !== 2'b01) begin
      errors++; $display("FAIL good_len: got %0d bytes, required 66 with last=1 err=0", gotQ.size());
    end
    checks++;
    if (goodCnt !== 1 || dropCnt !== 0 || errCnt !== 0) begin
      errors++; $display("FAIL good_cnt: got good=%0d drop=%0d err=%0d, required 1/0/0", goodCnt, dropCnt, errCnt);
    end
  endtask

  task automatic test_filter();
    int d;
    run_frame(7, 48'h02_00_00_00_00_99, 70);
    checks++;
    if (gotQ.size() !== 0 || dropCnt !== CW'(expDrop)) begin
      errors++; $display("FAIL filter_drop: got %0d bytes drop=%0d, required 0 bytes drop=%0d", gotQ.size(), dropCnt, expDrop);
    end
    promisc = 1'b1;
    run_frame(7, 48'h02_00_00_00_00_99, 70);
    d = frame_diff();
    checks++;
    if (d != -1 || gotQ.size() !== 66) begin errors++; $display("FAIL filter_promisc: diff at %0d, got %0d bytes, required 66", d, gotQ.size()); end
    promisc = 1'b0;
    run_frame(3, BCAST, 70);
    d = frame_diff();
    checks++;
    if (d != -1 || gotQ.size() !== 66) begin errors++; $display("FAIL filter_bcast: diff at %0d, got %0d bytes, required 66", d, gotQ.size()); end
    checks++;
    if (goodCnt !== CW'(expGood) || dropCnt !== CW'(expDrop) || errCnt !== CW'(expErr)) begin
      errors++; $display("FAIL filter_cnt: got %0d/%0d/%0d, required %0d/%0d/%0d", goodCnt, dropCnt, errCnt, expGood, expDrop, expErr);
    end
  endtask

  task automatic test_runt();
    int d;
    run_frame(7, STATION, 20);
    d = frame_diff();
    checks++;
    if (d != -1 || gotQ.size() !== 16 || gotQ[gotQ.size()-1][9:8] !== 2'b11) begin
      errors++; $display("FAIL runt: diff at %0d, got %0d bytes, required 16 ending last+err", d, gotQ.size());
    end
    checks++;
    if (errCnt !== CW'(expErr) || errCnt !== 1) begin
      errors++; $display("FAIL runt_cnt: got err=%0d, required 1", errCnt);
    end
  endtask

  task automatic test_giant();
    int d;
    run_frame(7, STATION, 1600);
    d = frame_diff();
    checks++;
    if (d != -1 || gotQ.size() !== 1514 || gotQ[gotQ.size()-1][9:8] !== 2'b11) begin
      errors++; $display("FAIL giant: diff at %0d, got %0d bytes, required 1514 ending last+err", d, gotQ.size());
    end
    checks++;
    if (errCnt !== 2) begin errors++; $display("FAIL giant_cnt: got err=%0d, required 2", errCnt); end
    run_frame(7, STATION, 80);
    d = frame_diff();
    checks++;
    if (d != -1 || gotQ.size() !== 76) begin errors++; $display("FAIL giant_next: diff at %0d, got %0d bytes, required 76", d, gotQ.size()); end
  endtask

  task automatic test_bad_preamble();
    logic [7:0] q[$];
    int d, dropBefore;
    dropBefore = expDrop;
    q = {8'h55, 8'h55, 8'hA3};
    repeat (60) q.push_back(8'($urandom));
    gotQ = {}; expQ = {};
    model_frame(q);
    drive_frame(q, 1'b0);
    checks++;
    if (gotQ.size() !== 0 || dropCnt !== CW'(dropBefore + 1)) begin
      errors++; $display("FAIL bad_preamble: got %0d bytes drop=%0d, required 0 bytes drop=%0d", gotQ.size(), dropCnt, dropBefore + 1);
    end
    run_frame(7, STATION, 64);
    d = frame_diff();
    checks++;
    if (d != -1 || gotQ.size() !== 60) begin errors++; $display("FAIL bad_preamble_next: diff at %0d, got %0d bytes, required 60", d, gotQ.size()); end
  endtask

  task automatic test_random();
    for (int f = 0; f < 24; f++) begin
      logic [7:0]  q[$];
      logic [47:0] dest;
      int preLen, len, r, d;
      preLen = $urandom_range(1, 7);
      case ($urandom_range(0, 3))
        0:       dest = STATION;
        1:       dest = BCAST;
        2:       dest = {16'($urandom), 32'($urandom)};
        default: dest = STATION ^ 48'h1;
      endcase
      promisc = ($urandom_range(0, 3) == 0);
      r = $urandom_range(0, 9);
      if (r == 0)      len = $urandom_range(0, 5);
      else if (r < 3)  len = $urandom_range(6, 63);
      else             len = $urandom_range(64, 120);
      build_frame(q, preLen, dest, len);
      if ($urandom_range(0, 7) == 0) q[$urandom_range(0, preLen)] = 8'hA3;
      gotQ = {}; expQ = {};
      model_frame(q);
      drive_frame(q, 1'b1);
      d = frame_diff();
      checks++;
      if (d != -1) begin
        errors++; $display("FAIL random_frame %0d: diff at %0d, got %0d bytes, required %0d", f, d, gotQ.size(), expQ.size());
      end
    end
    promisc = 1'b0;
    checks++;
    if (goodCnt !== CW'(expGood) || dropCnt !== CW'(expDrop) || errCnt !== CW'(expErr)) begin
      errors++; $display("FAIL random_cnt: got %0d/%0d/%0d, required %0d/%0d/%0d", goodCnt, dropCnt, errCnt, expGood, expDrop, expErr);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] q[$];
    int d;
    build_frame(q, 7, STATION, 70);
    gotQ = {};
    for (int k = 0; k <= 8 + 30; k++) begin
      bus.rxDataValidIn = 1'b1;
      bus.rxDataIn      = q[k];
      @(posedge clkIn); #1;
    end
    checks++;
    if (bus.frmValidOut !== 1'b1) begin errors++; $display("FAIL mid_frame_active: got valid=%b, required 1", bus.frmValidOut); end
    #2 rstNIn = 1'b0;
    #1;
    checks++;
    if ({bus.frmValidOut, bus.frmLastOut, bus.frmErrOut, bus.frmDataOut, goodCnt, dropCnt, errCnt} !== '0) begin
      errors++;
      $display("FAIL reset_mid: got v=%b l=%b e=%b d=%h good=%0d drop=%0d err=%0d, required all 0",
               bus.frmValidOut, bus.frmLastOut, bus.frmErrOut, bus.frmDataOut, goodCnt, dropCnt, errCnt);
    end
    bus.rxDataValidIn = 1'b0;
    repeat (2) @(posedge clkIn);
    #3 rstNIn = 1'b1;
    @(posedge clkIn); #1;
    expGood = 0; expDrop = 0; expErr = 0;
    run_frame(7, STATION, 70);
    d = frame_diff();
    checks++;
    if (d != -1 || goodCnt !== 1 || dropCnt !== 0 || errCnt !== 0) begin
      errors++; $display("FAIL reset_recover: diff at %0d, got good=%0d drop=%0d err=%0d, required 1/0/0", d, goodCnt, dropCnt, errCnt);
    end
  endtask

  initial begin
    bus.rxDataIn      = 8'h00;
    bus.rxDataValidIn = 1'b0;
    bus.rxDataLastIn  = 1'b0;
    macAddr           = STATION;
    promisc           = 1'b0;
    test_reset();
    test_good();
    test_filter();
    test_runt();
    test_giant();
    test_bad_preamble();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
